// File: rtl/router_fifo.sv
// Per-destination output buffer of the 1x3 router: a 16-deep FIFO of header-tagged bytes
// with a packet-length counter that clears data_out once a packet's parity byte has been read.
module router_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  logic [WIDTH:0]   mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [6:0]       pkt_cnt_q, pkt_cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             do_wr, do_rd, mem_we;
  logic [WIDTH:0]   rd_word;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data_out = data_out_q;

  always_comb begin
    do_wr      = write_enb && !full;
    do_rd      = read_enb && !empty;
    mem_we     = do_wr && !soft_reset;
    rd_word    = mem_q[rd_ptr_q[AW-1:0]];
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pkt_cnt_d  = pkt_cnt_q;
    data_out_d = data_out_q;
    if (soft_reset) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      pkt_cnt_d  = '0;
      data_out_d = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) begin
        rd_ptr_d   = rd_ptr_q + 1'b1;
        data_out_d = rd_word[WIDTH-1:0];
        // Header byte carries payload length in [7:2]; +1 accounts for the parity byte.
        if (rd_word[WIDTH])
          pkt_cnt_d = {1'b0, rd_word[7:2]} + 7'd1;
        else if (pkt_cnt_q != 7'd0)
          pkt_cnt_d = pkt_cnt_q - 7'd1;
      end else if (pkt_cnt_q == 7'd0) begin
        data_out_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pkt_cnt_q  <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
  end

endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo: reset, packet readout with length tracking, full/empty,
// concurrent read/write across pointer wrap, soft flush and asynchronous reset mid-read.
module tb_router_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       soft_reset = 1'b0;
  logic       write_enb = 1'b0;
  logic       read_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       full, empty;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] exp_q [$];
  logic [7:0] pkt2 [10];
  logic [7:0] front;
  logic [4:0] occ;

  router_fifo #(.WIDTH(8), .DEPTH(16), .AW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_enb = 1'b0;
    read_enb  = 1'b0;
    lfd_state = 1'b0;
  endtask

  task automatic wr(input logic [7:0] b, input logic lfd);
    write_enb = 1'b1;
    read_enb  = 1'b0;
    lfd_state = lfd;
    data_in   = b;
    step();
  endtask

  initial begin
    // 1. reset
    #10 rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_dout", data_out, 8'h00);
    read_enb = 1'b1;
    step();
    idle();
    chk("rd_on_empty_dout", data_out, 8'h00);
    chk("rd_on_empty_empty", empty, 1);

    // 2. header 0x22 -> 8 payload + parity
    pkt2[0] = 8'h22;
    for (int i = 1; i <= 8; i++) pkt2[i] = 8'h10 + 8'(i);
    pkt2[9] = 8'h00;
    for (int i = 0; i < 9; i++) pkt2[9] = pkt2[9] ^ pkt2[i];
    for (int i = 0; i < 10; i++) wr(pkt2[i], (i == 0));
    idle();
    chk("pkt_not_empty", empty, 0);
    for (int i = 0; i < 10; i++) begin
      read_enb = 1'b1;
      step();
      chk($sformatf("pkt_dout_%0d", i), data_out, pkt2[i]);
      chk($sformatf("pkt_cnt_%0d", i), dut.pkt_cnt_q, 32'(9 - i));
    end
    idle();
    chk("pkt_empty_after", empty, 1);
    step();
    chk("pkt_dout_cleared", data_out, 8'h00);

    // 3. fill to full, overflow dropped, drain
    for (int i = 0; i < 16; i++) begin
      wr(8'h30 + 8'(i), 1'b0);
      if (i == 14) chk("full_at_15", full, 0);
    end
    chk("full_at_16", full, 1);
    chk("full_not_empty", empty, 0);
    wr(8'hEE, 1'b0);
    idle();
    chk("full_after_17th", full, 1);
    for (int i = 0; i < 16; i++) begin
      read_enb = 1'b1;
      step();
      chk($sformatf("drain_%0d", i), data_out, 8'h30 + 8'(i));
      if (i == 0) chk("drain_not_full", full, 0);
    end
    idle();
    chk("drain_empty", empty, 1);
    step();

    // 4. 5 stored, 20 cycles concurrent read+write across wrap
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      wr(8'h50 + 8'(i), 1'b0);
      exp_q.push_back(8'h50 + 8'(i));
    end
    idle();
    for (int k = 0; k < 20; k++) begin
      read_enb  = 1'b1;
      write_enb = 1'b1;
      lfd_state = 1'b0;
      data_in   = 8'h60 + 8'(k);
      front = exp_q.pop_front();
      exp_q.push_back(8'h60 + 8'(k));
      step();
      occ = dut.wr_ptr_q - dut.rd_ptr_q;
      chk($sformatf("rw_dout_%0d", k), data_out, front);
      chk($sformatf("rw_occ_%0d", k), occ, 5);
      chk($sformatf("rw_flags_%0d", k), {full, empty}, 2'b00);
    end
    idle();
    for (int i = 0; i < 5; i++) begin
      read_enb = 1'b1;
      front = exp_q.pop_front();
      step();
      chk($sformatf("rw_tail_%0d", i), data_out, front);
    end
    idle();
    chk("rw_final_empty", empty, 1);
    step();

    // 5. soft_reset with 6 stored and concurrent write
    for (int i = 0; i < 7; i++) wr(8'h70 + 8'(i), 1'b0);
    idle();
    read_enb = 1'b1;
    step();
    chk("soft_pre_dout", data_out, 8'h70);
    read_enb   = 1'b0;
    soft_reset = 1'b1;
    write_enb  = 1'b1;
    data_in    = 8'hC3;
    step();
    soft_reset = 1'b0;
    idle();
    chk("soft_empty", empty, 1);
    chk("soft_full", full, 0);
    chk("soft_dout", data_out, 8'h00);
    chk("soft_wr_ignored", dut.wr_ptr_q, 0);
    step();
    chk("soft_still_empty", empty, 1);

    // 6. async reset mid-read, then 0x06 packet
    wr(8'h10, 1'b1);
    wr(8'h01, 1'b0);
    wr(8'h02, 1'b0);
    idle();
    read_enb = 1'b1;
    step();
    chk("mid_first_dout", data_out, 8'h10);
    #2 rst = 1'b0;
    #1;
    chk("async_dout", data_out, 8'h00);
    chk("async_empty", empty, 1);
    chk("async_full", full, 0);
    idle();
    @(posedge clk);
    #3 rst = 1'b1;
    step();
    chk("post_rst_empty", empty, 1);
    wr(8'h06, 1'b1);
    wr(8'hA5, 1'b0);
    wr(8'hA3, 1'b0);
    idle();
    read_enb = 1'b1;
    step();
    chk("p6_hdr", data_out, 8'h06);
    chk("p6_cnt0", dut.pkt_cnt_q, 2);
    step();
    chk("p6_pay", data_out, 8'hA5);
    chk("p6_cnt1", dut.pkt_cnt_q, 1);
    step();
    chk("p6_par", data_out, 8'hA3);
    chk("p6_cnt2", dut.pkt_cnt_q, 0);
    idle();
    step();
    chk("p6_cleared", data_out, 8'h00);
    chk("p6_empty", empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
